// File: rtl/mips_datapath_memory_bam_pipe_pkg.sv
// Shared encodings for the byte-addressable data memory: enable/extend codes,
// clear-sequencer states and the access-size helper.
package mips_datapath_memory_bam_pipe_pkg;

  typedef enum logic [1:0] {
    BE_NONE = 2'd0,
    BE_BYTE = 2'd1,
    BE_HALF = 2'd2,
    BE_WORD = 2'd3
  } byte_enable_t;

  typedef enum logic {
    EXT_UNSIGNED = 1'b0,
    EXT_SIGNED   = 1'b1
  } byte_extend_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mips_datapath_memory_clear_state_t;

  localparam int BUS_BYTES = 4;

  function automatic logic [2:0] size_of(input byte_enable_t en);
    case (en)
      BE_BYTE: return 3'd1;
      BE_HALF: return 3'd2;
      BE_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mips_datapath_memory_bam_pipe_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface mips_datapath_memory_bam_pipe_if #(
  parameter int ADDR_W = 6
);
  import mips_datapath_memory_bam_pipe_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  byte_enable_t      req_enable;
  byte_extend_t      req_extend;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic              resp_fault;
  logic              busy_clear;

  modport master (
    output req_valid, req_write, req_enable, req_extend, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_fault, busy_clear
  );

  modport slave (
    input  req_valid, req_write, req_enable, req_extend, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_fault, busy_clear
  );

endinterface

// File: rtl/mips_datapath_memory_bam_pipe_lane_format.sv
// Byte ordering for a 4-byte window at the request address: load assembly with
// zero/sign extension, and store scatter with a per-byte write mask.
module mips_datapath_memory_lane_format
  import mips_datapath_memory_bam_pipe_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  byte_enable_t i_enable,
  input  byte_extend_t i_extend,
  input  logic [31:0]  i_rd_bytes,
  input  logic [31:0]  i_wr_data,
  output logic [31:0]  o_ld_data,
  output logic [31:0]  o_wr_bytes,
  output logic [3:0]   o_wr_mask
);

  logic [2:0]  w_size;
  logic [31:0] w_value;

  assign w_size = size_of(i_enable);

  // Window byte k maps to value byte k (little) or size-1-k (big).
  function automatic int lane(input int k, input int sz);
    return (BIG_ENDIAN != 0) ? (sz - 1 - k) : k;
  endfunction

  always_comb begin
    w_value    = '0;
    o_wr_bytes = '0;
    o_wr_mask  = '0;
    for (int k = 0; k < BUS_BYTES; k++) begin
      if (k < int'(w_size)) begin
        w_value[8*lane(k, int'(w_size)) +: 8] = i_rd_bytes[8*k +: 8];
        o_wr_bytes[8*k +: 8] = i_wr_data[8*lane(k, int'(w_size)) +: 8];
        o_wr_mask[k] = 1'b1;
      end
    end
  end

  always_comb begin
    o_ld_data = w_value;
    if (i_extend == EXT_SIGNED) begin
      if (i_enable == BE_BYTE)
        o_ld_data = {{24{w_value[7]}}, w_value[7:0]};
      else if (i_enable == BE_HALF)
        o_ld_data = {{16{w_value[15]}}, w_value[15:0]};
    end
  end

endmodule

// File: rtl/mips_datapath_memory_bam_pipe.sv
// MEM-stage data memory: post-reset clear sequencer, alignment/range fault
// check, byte array and a one-entry back-pressurable response register.
//
// state    | meaning
// ST_CLEAR | writing RESET_BYTE four bytes per cycle, requests refused
// ST_RUN   | serving requests, latency 1
module mips_datapath_memory_bam_pipe
  import mips_datapath_memory_bam_pipe_pkg::*;
#(
  parameter int         ADDR_L     = 64,
  parameter int         ADDR_W     = $clog2(ADDR_L),
  parameter logic [7:0] RESET_BYTE = 8'h00,
  parameter int         BIG_ENDIAN = 0
) (
  input logic i_clk,
  input logic i_rst,
  mips_datapath_memory_bam_pipe_if.slave io_mem
);

  mips_datapath_memory_clear_state_t r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_resp_valid;
  logic              r_resp_fault;
  logic [31:0]       r_resp_data;
  logic [7:0]        r_mem [ADDR_L];

  logic              w_accept;
  logic              w_fault;
  logic              w_store;
  logic [2:0]        w_size;
  logic [ADDR_W:0]   w_end;
  logic [31:0]       w_rd_bytes;
  logic [31:0]       w_ld_data;
  logic [31:0]       w_wr_bytes;
  logic [3:0]        w_wr_mask;

  assign io_mem.req_ready  = (r_state == ST_RUN) && (!r_resp_valid || io_mem.resp_ready);
  assign io_mem.busy_clear = (r_state == ST_CLEAR);
  assign io_mem.resp_valid = r_resp_valid;
  assign io_mem.resp_data  = r_resp_data;
  assign io_mem.resp_fault = r_resp_fault;

  assign w_accept = io_mem.req_valid && io_mem.req_ready;
  assign w_size   = size_of(io_mem.req_enable);
  // One extra bit so an access running past the top is seen, not wrapped.
  assign w_end    = {1'b0, io_mem.req_addr} + (ADDR_W+1)'(w_size);
  assign w_fault  = (io_mem.req_enable == BE_HALF && io_mem.req_addr[0]) ||
                    (io_mem.req_enable == BE_WORD && io_mem.req_addr[1:0] != 2'b00) ||
                    (w_end > (ADDR_W+1)'(ADDR_L));
  assign w_store  = w_accept && io_mem.req_write && !w_fault;

  always_comb begin
    w_rd_bytes = '0;
    for (int k = 0; k < BUS_BYTES; k++) begin
      if (int'(io_mem.req_addr) + k < ADDR_L)
        w_rd_bytes[8*k +: 8] = r_mem[io_mem.req_addr + ADDR_W'(k)];
    end
  end

  mips_datapath_memory_lane_format #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .i_enable  (io_mem.req_enable),
    .i_extend  (io_mem.req_extend),
    .i_rd_bytes(w_rd_bytes),
    .i_wr_data (io_mem.req_data),
    .o_ld_data (w_ld_data),
    .o_wr_bytes(w_wr_bytes),
    .o_wr_mask (w_wr_mask)
  );

  // Array has no reset of its own so it maps onto synchronous RAM.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == ST_CLEAR) begin
        for (int k = 0; k < BUS_BYTES; k++)
          r_mem[r_clr_ptr + ADDR_W'(k)] <= RESET_BYTE;
      end else if (w_store) begin
        for (int k = 0; k < BUS_BYTES; k++)
          if (w_wr_mask[k])
            r_mem[io_mem.req_addr + ADDR_W'(k)] <= w_wr_bytes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_CLEAR;
      r_clr_ptr    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + ADDR_W'(4);
        if (r_clr_ptr == ADDR_W'(ADDR_L - 4)) begin
          r_state   <= ST_RUN;
          r_clr_ptr <= '0;
        end
      end
      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_resp_fault <= w_fault;
        r_resp_data  <= (!io_mem.req_write && !w_fault) ? w_ld_data : 32'h0;
      end else if (io_mem.resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_datapath_memory_bam_pipe.sv
// Bench for the data memory: a little-endian and a big-endian instance share
// one stimulus stream and are each checked against a byte-array model.
module tb_mips_datapath_memory_bam_pipe;
  import mips_datapath_memory_bam_pipe_pkg::*;

  localparam int ADDR_L = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         t_valid = 1'b0;
  logic         t_write = 1'b0;
  logic         t_rr    = 1'b1;
  byte_enable_t t_en    = BE_NONE;
  byte_extend_t t_ext   = EXT_UNSIGNED;
  logic [5:0]   t_addr  = '0;
  logic [31:0]  t_data  = '0;

  mips_datapath_memory_bam_pipe_if #(.ADDR_W(ADDR_W)) if_le ();
  mips_datapath_memory_bam_pipe_if #(.ADDR_W(ADDR_W)) if_be ();

  assign if_le.req_valid  = t_valid;
  assign if_le.req_write  = t_write;
  assign if_le.req_enable = t_en;
  assign if_le.req_extend = t_ext;
  assign if_le.req_addr   = t_addr;
  assign if_le.req_data   = t_data;
  assign if_le.resp_ready = t_rr;
  assign if_be.req_valid  = t_valid;
  assign if_be.req_write  = t_write;
  assign if_be.req_enable = t_en;
  assign if_be.req_extend = t_ext;
  assign if_be.req_addr   = t_addr;
  assign if_be.req_data   = t_data;
  assign if_be.resp_ready = t_rr;

  mips_datapath_memory_bam_pipe #(
    .ADDR_L(ADDR_L), .ADDR_W(ADDR_W), .RESET_BYTE(8'h00), .BIG_ENDIAN(0)
  ) u_le (
    .i_clk(clk), .i_rst(rst), .io_mem(if_le)
  );

  mips_datapath_memory_bam_pipe #(
    .ADDR_L(ADDR_L), .ADDR_W(ADDR_W), .RESET_BYTE(8'hA5), .BIG_ENDIAN(1)
  ) u_be (
    .i_clk(clk), .i_rst(rst), .io_mem(if_be)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [2][ADDR_L];

  typedef struct {
    bit           wr;
    byte_enable_t en;
    byte_extend_t ext;
    logic [5:0]   addr;
    logic [31:0]  data;
    logic [31:0]  exp_le;
    logic [31:0]  exp_be;
    bit           exp_f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ADDR_L; i++) begin
      m_mem[0][i] = 8'h00;
      m_mem[1][i] = 8'hA5;
    end
  endtask

  // Reference: byte array accessed by address arithmetic, be selects endianness.
  task automatic model_access(input int be, input bit wr, input int en, input bit ext,
                              input int addr, input logic [31:0] data,
                              output logic [31:0] d, output bit f);
    int     sz;
    longint v;
    sz = (en == 1) ? 1 : (en == 2) ? 2 : (en == 3) ? 4 : 0;
    f  = (en == 2 && addr % 2 != 0) || (en == 3 && addr % 4 != 0) || (addr + sz > ADDR_L);
    d  = 32'h0;
    if (!f && sz > 0) begin
      if (wr) begin
        for (int k = 0; k < sz; k++)
          m_mem[be][addr + ((be != 0) ? sz - 1 - k : k)] = data[8*k +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < sz; i++)
          v += longint'(m_mem[be][addr + i]) << (8 * ((be != 0) ? sz - 1 - i : i));
        if (ext && sz < 4 && v >= (longint'(1) << (8*sz - 1)))
          v -= longint'(1) << (8*sz);
        d = v[31:0];
      end
    end
  endtask

  function automatic vec_t mk(input bit wr, input byte_enable_t en, input byte_extend_t ext,
                              input logic [5:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_le, input logic [31:0] exp_be, input bit exp_f);
    vec_t v;
    v.wr = wr; v.en = en; v.ext = ext; v.addr = addr; v.data = data;
    v.exp_le = exp_le; v.exp_be = exp_be; v.exp_f = exp_f;
    return v;
  endfunction

  // Entered and left at posedge+1; one request with resp_ready held high.
  task automatic txn(input string name, input vec_t v);
    logic [31:0] d;
    bit          f;
    model_access(0, v.wr, int'(v.en), v.ext == EXT_SIGNED, int'(v.addr), v.data, d, f);
    model_access(1, v.wr, int'(v.en), v.ext == EXT_SIGNED, int'(v.addr), v.data, d, f);
    t_valid = 1'b1; t_write = v.wr; t_en = v.en; t_ext = v.ext;
    t_addr = v.addr; t_data = v.data; t_rr = 1'b1;
    @(negedge clk);
    check({name, "_req_ready"}, if_le.req_ready, 1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(negedge clk);
    check({name, "_le_valid"}, if_le.resp_valid, 1);
    check({name, "_be_valid"}, if_be.resp_valid, 1);
    check({name, "_le_data"}, if_le.resp_data, v.exp_le);
    check({name, "_be_data"}, if_be.resp_data, v.exp_be);
    check({name, "_le_fault"}, if_le.resp_fault, v.exp_f);
    check({name, "_be_fault"}, if_be.resp_fault, v.exp_f);
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1 right after reset release; counts clearing cycles.
  task automatic count_clear(input string name);
    int n_le = 0;
    int n_be = 0;
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({name, "_resp_valid"}, if_le.resp_valid, 0);
        check({name, "_resp_data"}, if_le.resp_data, 0);
        check({name, "_resp_fault"}, if_le.resp_fault, 0);
        check({name, "_be_resp_valid"}, if_be.resp_valid, 0);
      end
      if (if_le.busy_clear && !if_le.req_ready) n_le++;
      if (if_be.busy_clear && !if_be.req_ready) n_be++;
      if (!if_le.busy_clear && !if_be.busy_clear) done = 1'b1;
    end
    check({name, "_clear_cycles_le"}, n_le, 16);
    check({name, "_clear_cycles_be"}, n_be, 16);
    check({name, "_ready_after"}, if_le.req_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ea_le, ea_be, eb_le, eb_be, ec_le, ec_be, d;
    bit          f;
    logic [31:0] q_le[$];
    logic [31:0] q_be[$];
    bit          q_f[$];

    // Power-on reset and full clear.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", if_le.busy_clear, 1);
    check("rst_req_ready", if_le.req_ready, 0);
    check("rst_resp_valid", if_le.resp_valid, 0);
    check("rst_resp_data", if_be.resp_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_clear("init");
    model_reset();

    vecs.push_back(mk(0, BE_WORD, EXT_UNSIGNED, 6'd0,  32'h0,        32'h00000000, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(1, BE_WORD, EXT_UNSIGNED, 6'd8,  32'h8899AABB, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, BE_BYTE, EXT_SIGNED,   6'd8,  32'h0,        32'hFFFFFFBB, 32'hFFFFFF88, 0));
    vecs.push_back(mk(0, BE_HALF, EXT_UNSIGNED, 6'd10, 32'h0,        32'h00008899, 32'h0000AABB, 0));
    vecs.push_back(mk(1, BE_WORD, EXT_UNSIGNED, 6'd4,  32'h11223344, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, BE_BYTE, EXT_UNSIGNED, 6'd4,  32'h0,        32'h00000044, 32'h00000011, 0));
    vecs.push_back(mk(0, BE_HALF, EXT_SIGNED,   6'd6,  32'h0,        32'h00001122, 32'h00003344, 0));
    vecs.push_back(mk(1, BE_HALF, EXT_UNSIGNED, 6'd3,  32'h0000FFFF, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, BE_WORD, EXT_UNSIGNED, 6'd2,  32'h0,        32'h0,        32'h0,        1));
    vecs.push_back(mk(0, BE_WORD, EXT_UNSIGNED, 6'd62, 32'h0,        32'h0,        32'h0,        1));
    vecs.push_back(mk(0, BE_HALF, EXT_SIGNED,   6'd63, 32'h0,        32'h0,        32'h0,        1));
    vecs.push_back(mk(0, BE_WORD, EXT_UNSIGNED, 6'd0,  32'h0,        32'h00000000, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(0, BE_WORD, EXT_UNSIGNED, 6'd4,  32'h0,        32'h11223344, 32'h11223344, 0));
    vecs.push_back(mk(0, BE_WORD, EXT_UNSIGNED, 6'd60, 32'h0,        32'h00000000, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(1, BE_NONE, EXT_UNSIGNED, 6'd8,  32'hFFFFFFFF, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, BE_NONE, EXT_SIGNED,   6'd8,  32'h0,        32'h0,        32'h0,        0));
    vecs.push_back(mk(0, BE_WORD, EXT_SIGNED,   6'd8,  32'h0,        32'h8899AABB, 32'h8899AABB, 0));
    vecs.push_back(mk(1, BE_BYTE, EXT_UNSIGNED, 6'd9,  32'h123456C3, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, BE_HALF, EXT_SIGNED,   6'd8,  32'h0,        32'hFFFFC3BB, 32'hFFFF88C3, 0));
    vecs.push_back(mk(1, BE_HALF, EXT_UNSIGNED, 6'd12, 32'h00007E01, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, BE_WORD, EXT_UNSIGNED, 6'd12, 32'h0,        32'h00007E01, 32'h7E01A5A5, 0));
    vecs.push_back(mk(0, BE_BYTE, EXT_SIGNED,   6'd13, 32'h0,        32'h0000007E, 32'h00000001, 0));
    vecs.push_back(mk(1, BE_BYTE, EXT_UNSIGNED, 6'd63, 32'h000000D5, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, BE_BYTE, EXT_SIGNED,   6'd63, 32'h0,        32'hFFFFFFD5, 32'hFFFFFFD5, 0));

    foreach (vecs[i]) txn($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: hold a load response for 3 cycles, then back-to-back.
    model_access(0, 0, 3, 0, 4, 0, ea_le, f);
    model_access(1, 0, 3, 0, 4, 0, ea_be, f);
    model_access(0, 0, 3, 0, 8, 0, eb_le, f);
    model_access(1, 0, 3, 0, 8, 0, eb_be, f);
    model_access(0, 0, 1, 0, 12, 0, ec_le, f);
    model_access(1, 0, 1, 0, 12, 0, ec_be, f);
    t_valid = 1'b1; t_write = 1'b0; t_en = BE_WORD; t_ext = EXT_UNSIGNED;
    t_addr = 6'd4; t_rr = 1'b0;
    @(posedge clk); #1;
    t_addr = 6'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", if_le.resp_valid, 1);
      check("stall_le_data", if_le.resp_data, ea_le);
      check("stall_be_data", if_be.resp_data, ea_be);
      check("stall_req_ready", if_le.req_ready, 0);
      @(posedge clk); #1;
    end
    t_rr = 1'b1;
    @(negedge clk);
    check("release_req_ready", if_le.req_ready, 1);
    @(posedge clk); #1;
    t_en = BE_BYTE; t_addr = 6'd12;
    @(negedge clk);
    check("b2b_valid_1", if_le.resp_valid, 1);
    check("b2b_le_data_1", if_le.resp_data, eb_le);
    check("b2b_be_data_1", if_be.resp_data, eb_be);
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid_2", if_le.resp_valid, 1);
    check("b2b_le_data_2", if_le.resp_data, ec_le);
    check("b2b_be_data_2", if_be.resp_data, ec_be);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_drained", if_le.resp_valid, 0);
    @(posedge clk); #1;

    // Randomised traffic against the model, with random back-pressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      int  a, sz;
      bit  exp_valid, exp_ready;
      t_valid = ($urandom_range(0, 3) != 0);
      t_rr    = ($urandom_range(0, 3) != 0);
      t_write = 1'($urandom_range(0, 1));
      t_en    = byte_enable_t'($urandom_range(0, 3));
      t_ext   = byte_extend_t'($urandom_range(0, 1));
      t_data  = $urandom;
      a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
      sz = (t_en == BE_BYTE) ? 1 : (t_en == BE_HALF) ? 2 : (t_en == BE_WORD) ? 4 : 0;
      if (sz > 1 && $urandom_range(0, 3) != 0) a = a - (a % sz);
      t_addr = 6'(a);
      if (cyc >= 396) begin
        t_valid = 1'b0;
        t_rr    = 1'b1;
      end
      @(negedge clk);
      exp_valid = (q_le.size() != 0);
      exp_ready = !exp_valid || t_rr;
      check("rand_le_valid", if_le.resp_valid, exp_valid);
      check("rand_be_valid", if_be.resp_valid, exp_valid);
      check("rand_req_ready", if_le.req_ready, exp_ready);
      if (exp_valid) begin
        check("rand_le_data", if_le.resp_data, q_le[0]);
        check("rand_be_data", if_be.resp_data, q_be[0]);
        check("rand_le_fault", if_le.resp_fault, q_f[0]);
        check("rand_be_fault", if_be.resp_fault, q_f[0]);
        if (t_rr) begin
          void'(q_le.pop_front());
          void'(q_be.pop_front());
          void'(q_f.pop_front());
        end
      end
      if (t_valid && exp_ready) begin
        model_access(0, t_write, int'(t_en), t_ext == EXT_SIGNED, a, t_data, d, f);
        q_le.push_back(d);
        q_f.push_back(f);
        model_access(1, t_write, int'(t_en), t_ext == EXT_SIGNED, a, t_data, d, f);
        q_be.push_back(d);
      end
      @(posedge clk); #1;
    end
    check("rand_queue_empty", q_le.size(), 0);

    // Reset while a response is held: it is dropped and the clear restarts.
    txn("pre_rst_store", mk(1, BE_WORD, EXT_UNSIGNED, 6'd0, 32'hCAFEF00D, 32'h0, 32'h0, 0));
    t_valid = 1'b1; t_write = 1'b0; t_en = BE_WORD; t_ext = EXT_UNSIGNED;
    t_addr = 6'd0; t_rr = 1'b0;
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(negedge clk);
    check("held_valid", if_le.resp_valid, 1);
    check("held_le_data", if_le.resp_data, 32'hCAFEF00D);
    check("held_be_data", if_be.resp_data, 32'hCAFEF00D);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t_rr = 1'b1;
    count_clear("rst_resp");

    // Reset again five cycles into a clear.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_clear("rst_midclear");
    model_reset();
    txn("post_clear", mk(0, BE_WORD, EXT_UNSIGNED, 6'd0, 32'h0, 32'h00000000, 32'hA5A5A5A5, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_datapath_memory_bam_pipe.md
Name: mips_datapath_memory_bam_pipe

Overview:
- Parametrised successor to the single-cycle byte-addressable data memory.
- Little- or big-endian byte array with a valid/ready request port and a registered, back-pressurable response port.
- Adds alignment/range fault detection and a post-reset clearing sequencer, so the array is realisable as synchronous RAM.
- Sits in the MEM stage; the pipeline stalls on req_ready=0 or resp_valid=0.

Parameters:
- ADDR_L, 64, array depth in bytes; multiple of 4, minimum 8.
- ADDR_W, log2(ADDR_L), request address width.
- RESET_BYTE, 8'h00, value written to every byte by the clear sequence.
- BIG_ENDIAN, 0, 0 = byte0 (LSB) at addr; 1 = MSB at addr.

Ports:
- ctrl  input  Data_Control_Control bundle  Clock and Reset fields. One clock; reset is synchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_enable  input  ByteEnable (2)  None/Byte/Half/Word.
- req_extend  input  ByteExtend (1)  Unsigned/Signed, loads only.
- req_addr  input  ADDR_W  byte address.
- req_data  input  32  store data; the low bytes are used for Byte/Half.
- resp_valid  output  1  response held until resp_ready.
- resp_ready  input  1  consumer accepts response.
- resp_data  output  32  load result; 0 for stores, faults and None.
- resp_fault  output  1  request was misaligned or out of range.
- busy_clear  output  1  clear sequence in progress.

Behaviour:
- States: CLEAR, RUN.
- Reset (sampled at posedge) has priority over everything, including a clear already in progress:
  - state=CLEAR, clear pointer=0, resp_valid=0, resp_data=0, resp_fault=0.
  - Any in-flight response is discarded.
- CLEAR:
  - Each cycle writes RESET_BYTE to 4 bytes at ptr..ptr+3, then ptr+=4.
  - After the write of ADDR_L-4, the next state is RUN.
  - Clearing takes exactly ADDR_L/4 cycles.
  - busy_clear=1 and req_ready=0 throughout.
- RUN:
  - req_ready = !resp_valid || resp_ready. This is a one-entry output register with full-throughput pass-through.
  - Accept at edge N gives resp_valid=1 after edge N, i.e. latency 1.
  - The response is stable while resp_valid && !resp_ready.
  - resp_valid clears at an edge where resp_ready=1 and no new accept occurs.
- Size: None=0, Byte=1, Half=2, Word=4.
- Fault:
  - Half with addr[0]!=0.
  - Word with addr[1:0]!=0.
  - addr+size > ADDR_L, computed in ADDR_W+1 bits with no wrap-around.
  - A faulting request is accepted normally: no array write, resp_fault=1, resp_data=0.
- Store (non-fault):
  - Writes exactly size bytes at the accept edge.
  - Little-endian: byte k of req_data goes to addr+k.
  - Big-endian: byte k goes to addr+size-1-k.
  - Response returns resp_data=0, resp_fault=0.
- Load (non-fault):
  - Bytes are assembled per endianness into the low size bytes.
  - Upper bytes are zero when Unsigned, or copies of the MSB of the loaded value when Signed.
  - Word loads ignore req_extend.
- None enable: no access, response with data 0 and fault 0.
- Load after store to the same bytes in the next accepted request returns the new data; the array is written before the following read.
- Simultaneous resp_ready and a new accept: the old response retires and the new one loads in the same edge.
- Undefined enable encodings are treated as None.

Decomposition:
- Shared package Mips_Control_Signal_Memory:
  - ByteEnable and ByteExtend encodings and the size function.
  - New FSM state encoding Mips_Datapath_Memory_ClearState_T (CLEAR, RUN).
- Sub-module mips_datapath_memory_lane_format:
  - Combinational byte ordering plus extension for loads, and byte scatter for stores.
  - Parametrised by BIG_ENDIAN and reused by the instruction-fetch memory.
- The top level holds the FSM, the fault check, the array and the response register.

Test Plan:
- Reset with ADDR_L=64 → busy_clear=1 and req_ready=0 for exactly 16 cycles, then req_ready=1; a Word load of addr 0 returns 0x00000000.
- BIG_ENDIAN=0: store Word 0x8899AABB at 8, then load Byte Signed at 8 → 0xFFFFFFBB. Load Half Unsigned at 10 → 0x00008899.
- BIG_ENDIAN=1: store Word 0x11223344 at 4 → load Byte at 4 = 0x00000011; load Half Signed at 6 = 0x00003344.
- Store Half at 3, load Word at 2, and Word access at 62 (ADDR_L=64) → resp_fault=1, resp_data=0. A subsequent load of addr 0 shows memory unchanged.
- Hold resp_ready=0 for 3 cycles after a load → resp_valid and resp_data remain stable and req_ready=0. Then resp_ready=1 with a new request → back-to-back responses with no bubble.
- Assert Reset mid-clear (cycle 5) and with resp_valid=1 → resp_valid drops next cycle, clear restarts from 0, and takes a full 16 cycles.
